// File: rtl/vga_fifo_refill_ctrl_if.sv
// rtl/vga_fifo_refill_ctrl_if.sv - SDRAM burst-read and line-FIFO write port bundle
interface vga_fifo_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 9
) ();
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  rd_len;
  logic                  rd_ack;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  fifo_half_full;
  logic                  fifo_full;
  logic                  fifo_we;
  logic [DATA_WIDTH-1:0] fifo_wdata;

  // The refill scheduler side: issues bursts, writes the FIFO
  modport master (
    output rd_req, rd_addr, rd_len, fifo_we, fifo_wdata,
    input  rd_ack, rd_valid, rd_data, fifo_half_full, fifo_full
  );

  // The SDRAM controller / FIFO side
  modport slave (
    input  rd_req, rd_addr, rd_len, fifo_we, fifo_wdata,
    output rd_ack, rd_valid, rd_data, fifo_half_full, fifo_full
  );
endinterface

// File: rtl/vga_fifo_refill_ctrl.sv
// rtl/vga_fifo_refill_ctrl.sv - keeps the VGA line FIFO topped up with SDRAM bursts
module vga_fifo_refill_ctrl #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int LEN_WIDTH   = 9,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  vga_fifo_refill_ctrl_if.master bus,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   busy
);
  localparam int OFF_WIDTH = $clog2(FRAME_WORDS + 1);
  localparam logic [OFF_WIDTH-1:0] FRAME_END = OFF_WIDTH'(FRAME_WORDS);

  typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, DONE} state_t;

  state_t               state;
  logic [OFF_WIDTH-1:0] offset;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [31:0]          words_left;
  logic [LEN_WIDTH-1:0] next_len;
  logic                 last_beat;
  logic                 frame_end_hit;

  // Next burst is clipped so it never runs past the end of the frame
  assign words_left    = 32'(FRAME_WORDS) - 32'(offset);
  assign next_len      = (words_left < 32'(BURST_LEN)) ? LEN_WIDTH'(words_left)
                                                       : LEN_WIDTH'(BURST_LEN);
  assign last_beat     = (beat_cnt == LEN_WIDTH'(1));
  assign frame_end_hit = ((offset + OFF_WIDTH'(1)) == FRAME_END);

  // Busy while a burst is being requested, received or drained
  assign busy = (state == REQ) || (state == DATA) || (state == DRAIN);

  // Refill scheduler: burst request, beat forwarding and frame restart handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      offset         <= '0;
      beat_cnt       <= '0;
      bus.rd_req     <= 1'b0;
      bus.rd_addr    <= '0;
      bus.rd_len     <= '0;
      bus.fifo_we    <= 1'b0;
      bus.fifo_wdata <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      bus.fifo_we <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            offset <= '0;
          end else if (enable && !bus.fifo_half_full && (offset < FRAME_END)) begin
            bus.rd_addr <= ADDR_WIDTH'(32'(FRAME_BASE) + 32'(offset));
            bus.rd_len  <= next_len;
            bus.rd_req  <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (frame_start) begin
            // An accepted burst is still owed by the SDRAM side and must be drained
            offset     <= '0;
            bus.rd_req <= 1'b0;
            if (bus.rd_ack) begin
              beat_cnt <= bus.rd_len;
              state    <= DRAIN;
            end else begin
              state <= IDLE;
            end
          end else if (bus.rd_ack) begin
            bus.rd_req <= 1'b0;
            beat_cnt   <= bus.rd_len;
            state      <= DATA;
          end
        end
        DATA: begin
          if (bus.rd_valid) begin
            bus.fifo_we    <= 1'b1;
            bus.fifo_wdata <= bus.rd_data;
            if (bus.fifo_full) overflow <= 1'b1;
            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            offset   <= offset + OFF_WIDTH'(1);
          end
          if (frame_start) begin
            offset <= '0;
            if (bus.rd_valid && last_beat) begin
              state <= IDLE;
            end else begin
              beat_cnt <= bus.rd_valid ? beat_cnt - LEN_WIDTH'(1) : beat_cnt;
              state    <= DRAIN;
            end
          end else if (bus.rd_valid && last_beat) begin
            if (frame_end_hit) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          // Beats belong to the abandoned frame: swallow them without writing
          offset <= '0;
          if (bus.rd_valid) begin
            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            if (last_beat) state <= IDLE;
          end
        end
        DONE: begin
          if (frame_start) begin
            offset <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fifo_refill_ctrl.sv
// tb/tb_vga_fifo_refill_ctrl.sv - scoreboard bench for the VGA FIFO refill scheduler
module tb_vga_fifo_refill_ctrl;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LW = 9;
  localparam int BL = 4;
  localparam int FB = 'h100;
  localparam int FW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          done;
    logic [31:0]   cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic frame_start = 1'b0;
  logic frame_done, overflow, busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_off = 0;
  logic exp_ovf = 1'b0;
  int   last_wait = 0;
  int   cfg_ack_dly, cfg_data0, cfg_restart, cfg_en_off, cfg_full_beat;

  req_t exp_req_q[$];
  wr_t  exp_wr_q[$];

  vga_fifo_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  vga_fifo_refill_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .BURST_LEN(BL), .FRAME_BASE(FB), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .bus(bus), .frame_done(frame_done), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_len();
    return (FW - m_off < BL) ? FW - m_off : BL;
  endfunction

  task automatic cfg_default();
    cfg_ack_dly = -1; cfg_data0 = -1; cfg_restart = -1; cfg_en_off = -1; cfg_full_beat = -1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a request or a FIFO write
  initial begin
    logic          prev_req;
    logic [AW-1:0] hold_addr;
    logic [LW-1:0] hold_len;
    req_t r;
    wr_t  w;
    prev_req = 1'b0;
    hold_addr = '0;
    hold_len = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.rd_req && !prev_req) begin
          if (exp_req_q.size() == 0) begin
            check("unexp_req", 32'(bus.rd_req), 0);
          end else begin
            r = exp_req_q.pop_front();
            check("req_addr", 32'(bus.rd_addr), 32'(r.addr));
            check("req_len", 32'(bus.rd_len), 32'(r.len));
          end
          hold_addr = bus.rd_addr;
          hold_len = bus.rd_len;
        end else if (bus.rd_req) begin
          check("req_hold", {bus.rd_addr, bus.rd_len}, {hold_addr, hold_len});
        end
        if (bus.fifo_we) begin
          if (exp_wr_q.size() == 0) begin
            check("unexp_we", 32'(bus.fifo_we), 0);
          end else begin
            w = exp_wr_q.pop_front();
            check("wr_data", 32'(bus.fifo_wdata), 32'(w.data));
            check("wr_done", 32'(frame_done), 32'(w.done));
            check("wr_cycle", cyc, w.cyc);
          end
        end else if (frame_done) begin
          check("done_no_we", 32'(frame_done), 0);
        end
      end
      prev_req = bus.rd_req;
    end
  end

  // One burst transaction; model decides the expected request and writes
  task automatic do_burst();
    int   len;
    int   dly;
    bit   restarted;
    logic [DW-1:0] d;
    req_t r;
    wr_t  w;
    len = exp_len();
    r.addr = AW'(FB + m_off);
    r.len = LW'(len);
    exp_req_q.push_back(r);
    last_wait = 0;
    while (!bus.rd_req && last_wait < 20) begin
      tick();
      last_wait++;
    end
    if (!bus.rd_req) begin
      check("req_timeout", 32'(bus.rd_req), 1);
      return;
    end
    dly = (cfg_ack_dly < 0) ? int'($urandom_range(0, 3)) : cfg_ack_dly;
    repeat (dly) tick();
    check("req_held", 32'(bus.rd_req), 1);
    bus.rd_ack = 1'b1;
    if (cfg_restart == -2) frame_start = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    frame_start = 1'b0;
    restarted = (cfg_restart == -2);
    if (restarted) m_off = 0;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == cfg_en_off) enable = 1'b0;
      if (i == cfg_restart && !restarted) begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        restarted = 1'b1;
        m_off = 0;
      end
      d = (cfg_data0 < 0) ? DW'($urandom) : DW'(cfg_data0 + i);
      bus.rd_valid = 1'b1;
      bus.rd_data = d;
      bus.fifo_full = (i == cfg_full_beat);
      if (cfg_restart == -3 && i == len - 1) frame_start = 1'b1;
      if (!restarted) begin
        w.data = d;
        w.done = (cfg_restart != -3) && (m_off + 1 == FW);
        w.cyc = cyc + 1;
        exp_wr_q.push_back(w);
        if (bus.fifo_full) exp_ovf = 1'b1;
        m_off++;
        if (cfg_restart == -3 && i == len - 1) m_off = 0;
      end
      tick();
      bus.rd_valid = 1'b0;
      bus.fifo_full = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   len;
    bus.rd_ack = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data = '0;
    bus.fifo_half_full = 1'b1;
    bus.fifo_full = 1'b0;
    cfg_default();

    // Reset state
    repeat (3) tick();
    check("rst_rd_req", 32'(bus.rd_req), 0);
    check("rst_rd_addr", 32'(bus.rd_addr), 0);
    check("rst_rd_len", 32'(bus.rd_len), 0);
    check("rst_fifo_we", 32'(bus.fifo_we), 0);
    check("rst_outs", {frame_done, overflow, busy}, 0);
    rst_n = 1'b1;
    enable = 1'b1;

    // Throttle: half-full holds off requests
    repeat (4) tick();
    check("throttle_req", 32'(bus.rd_req), 0);
    check("throttle_busy", 32'(busy), 0);

    // Basic burst, one-cycle request latency
    bus.fifo_half_full = 1'b0;
    cfg_ack_dly = 2;
    cfg_data0 = 'hA0;
    do_burst();
    check("half_full_to_req", last_wait, 1);
    cfg_default();

    // Rest of the frame: 0x104/4 then 0x108/2 with frame_done
    do_burst();
    do_burst();
    repeat (6) tick();
    check("done_no_req", 32'(bus.rd_req), 0);
    check("done_busy", 32'(busy), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_off = 0;

    // enable dropped mid-burst: burst completes, no follow-up request
    cfg_en_off = 2;
    do_burst();
    cfg_default();
    repeat (5) tick();
    check("en_off_req", 32'(bus.rd_req), 0);
    enable = 1'b1;

    // Restart after 2 of 4 beats
    cfg_restart = 2;
    do_burst();
    // Restart racing the ack
    cfg_restart = -2;
    do_burst();
    cfg_default();

    // Restart in REQ without ack: request withdrawn, no drain
    r.addr = AW'(FB);
    r.len = LW'(BL);
    exp_req_q.push_back(r);
    for (int k = 0; k < 20 && !bus.rd_req; k++) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("req_drop", 32'(bus.rd_req), 0);
    check("req_drop_busy", 32'(busy), 0);
    m_off = 0;

    // Overflow on a beat written while full
    cfg_full_beat = 1;
    do_burst();
    cfg_default();
    check("overflow_set", 32'(overflow), 1);
    do_burst();
    check("overflow_sticky", 32'(overflow), 1);

    // Randomized bursts against the model
    for (int n = 0; n < 40; n++) begin
      int sel;
      cfg_default();
      len = exp_len();
      sel = int'($urandom_range(0, 11));
      if (sel == 0) cfg_restart = int'($urandom_range(0, len - 1));
      else if (sel == 1) cfg_restart = -2;
      else if (sel == 2) cfg_restart = -3;
      if ($urandom_range(0, 7) == 0) cfg_full_beat = int'($urandom_range(0, len - 1));
      do_burst();
      if (m_off == FW) begin
        repeat ($urandom_range(0, 3)) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_off = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.fifo_half_full = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        bus.fifo_half_full = 1'b0;
      end
    end
    cfg_default();
    check("overflow_model", 32'(overflow), 32'(exp_ovf));

    // Asynchronous reset mid-DATA
    r.addr = AW'(FB + m_off);
    r.len = LW'(exp_len());
    exp_req_q.push_back(r);
    for (int k = 0; k < 20 && !bus.rd_req; k++) tick();
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_t w;
      bus.rd_valid = 1'b1;
      bus.rd_data = DW'($urandom);
      w.data = bus.rd_data;
      w.done = 1'b0;
      w.cyc = cyc + 1;
      exp_wr_q.push_back(w);
      tick();
      bus.rd_valid = 1'b0;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_rd_req", 32'(bus.rd_req), 0);
    check("arst_rd_addr", 32'(bus.rd_addr), 0);
    check("arst_rd_len", 32'(bus.rd_len), 0);
    check("arst_fifo_we", 32'(bus.fifo_we), 0);
    check("arst_outs", {frame_done, overflow, busy}, 0);
    exp_ovf = 1'b0;
    m_off = 0;
    bus.rd_valid = 1'b1;
    tick();
    enable = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    bus.rd_valid = 1'b0;
    check("stale_we", 32'(bus.fifo_we), 0);
    check("stale_busy", 32'(busy), 0);

    // Offset restarts at the frame base after reset
    enable = 1'b1;
    do_burst();
    bus.fifo_half_full = 1'b1;
    repeat (5) tick();
    check("end_req_q", exp_req_q.size(), 0);
    check("end_wr_q", exp_wr_q.size(), 0);
    check("end_overflow", 32'(overflow), 32'(exp_ovf));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
